// File: rtl/display_scan_controller_pkg.sv
// Shared digit-select codes, FSM state codes and configuration record for the
// scan controller, nibble mux and segment decoder.
package display_scan_controller_pkg;

  localparam logic [1:0] SEL_A = 2'b11;
  localparam logic [1:0] SEL_B = 2'b10;
  localparam logic [1:0] SEL_C = 2'b01;
  localparam logic [1:0] SEL_D = 2'b00;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SCAN = 1'b1;

  typedef struct packed {
    logic [3:0] bri;
    logic [3:0] mask;
  } cfg_t;

  localparam cfg_t CFG_RESET = '{bri: 4'hF, mask: 4'h0};

  // Active-low one-hot anode pattern for a select code (SEL_A drives bit3).
  function automatic logic [3:0] anode_onehot_n(input logic [1:0] sel);
    return ~(4'b0001 << sel);
  endfunction

endpackage

// File: rtl/refresh_timer.sv
// Slot and phase counters for the digit scan; outputs are lookahead values for
// the next cycle so the top can register selector and anodes on the same edge.
module refresh_timer #(
  parameter int REFRESH_DIV = 100000,
  parameter int DEAD_CYCLES = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       i_run,
  output logic       o_slotWrap,
  output logic [3:0] o_phase,
  output logic       o_inDeadTime
);

  localparam int Q  = REFRESH_DIV / 16;
  localparam int CW = $clog2(REFRESH_DIV);
  localparam int QW = $clog2(Q);
  localparam logic [CW-1:0] LAST  = CW'(REFRESH_DIV - 1);
  localparam logic [QW-1:0] QLAST = QW'(Q - 1);
  localparam logic [CW-1:0] DEAD  = CW'(DEAD_CYCLES);

  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [QW-1:0] r_sub, w_sub_nxt;
  logic [3:0]    r_ph,  w_ph_nxt;
  logic          w_wrap;

  assign w_wrap = i_run && (r_cnt == LAST);

  always_comb begin
    w_cnt_nxt = '0;
    w_sub_nxt = '0;
    w_ph_nxt  = '0;
    if (i_run && !w_wrap) begin
      w_cnt_nxt = r_cnt + CW'(1);
      if (r_sub == QLAST) begin
        w_sub_nxt = '0;
        w_ph_nxt  = r_ph + 4'd1;
      end else begin
        w_sub_nxt = r_sub + QW'(1);
        w_ph_nxt  = r_ph;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
      r_sub <= '0;
      r_ph  <= '0;
    end else begin
      r_cnt <= w_cnt_nxt;
      r_sub <= w_sub_nxt;
      r_ph  <= w_ph_nxt;
    end
  end

  assign o_slotWrap   = w_wrap;
  assign o_phase      = w_ph_nxt;
  assign o_inDeadTime = (w_cnt_nxt < DEAD);

endmodule

// File: rtl/display_scan_controller.sv
// Four-digit multiplexed display scanner with blanking dead time, PWM brightness
// and a frame-synchronous configuration handshake.
module display_scan_controller
  import display_scan_controller_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter int DEAD_CYCLES = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic       cfgValid,
  input  logic [3:0] cfgBrightness,
  input  logic [3:0] cfgBlankMask,
  output logic       cfgReady,
  output logic [1:0] selector,
  output logic [3:0] anodes,
  output logic       frameStart
);

  logic [0:0] r_state;
  logic [1:0] r_sel;
  logic [3:0] r_an;
  logic       r_fs, r_rdy;
  cfg_t       r_act, r_pend;

  logic       w_run, w_start, w_wrap, w_dead, w_fs_nxt, w_act, w_cap, w_lit;
  logic [3:0] w_phase, w_an_nxt;
  logic [1:0] w_sel_nxt;
  cfg_t       w_cfg;

  assign w_run   = (r_state == ST_SCAN) && enable;
  assign w_start = (r_state == ST_IDLE) && enable;

  refresh_timer #(
    .REFRESH_DIV (REFRESH_DIV),
    .DEAD_CYCLES (DEAD_CYCLES)
  ) u_timer (
    .clock        (clock),
    .reset        (reset),
    .i_run        (w_run),
    .o_slotWrap   (w_wrap),
    .o_phase      (w_phase),
    .o_inDeadTime (w_dead)
  );

  always_comb begin
    w_sel_nxt = r_sel;
    if (!enable || w_start) w_sel_nxt = SEL_A;
    else if (w_wrap)        w_sel_nxt = r_sel - 2'd1;
  end

  assign w_fs_nxt = w_start || (w_wrap && (r_sel == SEL_D));
  // Pending config applies at the next digit-A entry, or straight away when idle.
  assign w_act    = !r_rdy && ((r_state == ST_IDLE) || w_fs_nxt);
  assign w_cap    = cfgValid && r_rdy;
  assign w_cfg    = w_act ? r_pend : r_act;

  assign w_lit = enable && !w_dead && !w_cfg.mask[w_sel_nxt] &&
                 ((w_cfg.bri == 4'hF) || ((w_cfg.bri != 4'h0) && (w_phase < w_cfg.bri)));
  assign w_an_nxt = w_lit ? anode_onehot_n(w_sel_nxt) : 4'hF;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_sel   <= SEL_A;
      r_an    <= 4'hF;
      r_fs    <= 1'b0;
      r_rdy   <= 1'b1;
      r_act   <= CFG_RESET;
      r_pend  <= '0;
    end else begin
      r_state <= enable ? ST_SCAN : ST_IDLE;
      r_sel   <= w_sel_nxt;
      r_an    <= w_an_nxt;
      r_fs    <= w_fs_nxt;
      if (w_cap) r_pend <= '{bri: cfgBrightness, mask: cfgBlankMask};
      if (w_act) r_act  <= r_pend;
      if (w_cap)      r_rdy <= 1'b0;
      else if (w_act) r_rdy <= 1'b1;
    end
  end

  assign selector   = r_sel;
  assign anodes     = r_an;
  assign frameStart = r_fs;
  assign cfgReady   = r_rdy;

endmodule

// File: doc/display_scan_controller.md
DISPLAY_SCAN_CONTROLLER -- requirements
Module: display_scan_controller

Interface
REQ-001 Parameter REFRESH_DIV, default 100000, is the number of clock cycles per digit slot; it SHALL be a multiple of 16 and at least 64.
REQ-002 Parameter DEAD_CYCLES, default 16, is the number of blanked cycles at the start of each slot (anti-ghosting); it SHALL be less than REFRESH_DIV/16.
REQ-003 Port clock, input, 1: single clock domain; all state SHALL update on its rising edge.
REQ-004 Port reset, input, 1: asynchronous, active-high reset.
REQ-005 Port enable, input, 1: scanning runs while high.
REQ-006 Port cfgValid, input, 1: a new configuration is offered.
REQ-007 Port cfgBrightness, input, 4: duty level, where 0 is off and 15 is full.
REQ-008 Port cfgBlankMask, input, 4: per-digit blank; bit3 is digit A and bit0 is digit D.
REQ-009 Port cfgReady, output, 1: the block can accept a configuration.
REQ-010 Port selector, output, 2: nibble-mux select, where 2'b11=A, 2'b10=B, 2'b01=C and 2'b00=D.
REQ-011 Port anodes, output, 4: active-low digit enables; bit3 is digit A.
REQ-012 Port frameStart, output, 1: one-cycle pulse at the first cycle of each digit-A slot.

Function
REQ-013 States SHALL be IDLE and SCAN.
REQ-014 IDLE → SCAN on enable=1; the first slot SHALL be digit A with selector=2'b11 and slot counter 0.
REQ-015 SCAN → IDLE in the cycle after enable is sampled low, from any slot position.
REQ-016 In IDLE: anodes=4'b1111, selector holds 2'b11, and slot and phase counters are held at 0.
REQ-017 The slot counter SHALL count 0..REFRESH_DIV-1 and wrap.
REQ-018 On wrap, selector SHALL step A→B→C→D→A, i.e. 11→10→01→00→11.
REQ-019 The phase counter (4-bit) SHALL increment every REFRESH_DIV/16 cycles within a slot and reset to 0 at each slot start.
REQ-020 Exactly one anode SHALL be low when all of the following hold, otherwise all anodes are high:
- state is SCAN;
- slot counter ≥ DEAD_CYCLES;
- blankMask bit of the current digit is 0;
- brightness=15, or brightness≠0 and phase < brightness.
REQ-021 The low anode SHALL be the one matching selector.
REQ-022 selector and anodes SHALL be registered outputs that change on the same clock edge.
REQ-023 selector SHALL never change while any anode is low, since the dead time covers the transition.
REQ-024 frameStart SHALL pulse on entry to every digit-A slot, including the first slot after IDLE→SCAN.
REQ-025 Configuration handshake: when cfgValid && cfgReady, the inputs SHALL be captured into a pending register and cfgReady SHALL drop in the next cycle.
REQ-026 In SCAN, pending configuration SHALL become active at the next digit-A slot start, coincident with frameStart; cfgReady SHALL rise in that same cycle.
REQ-027 In IDLE, pending configuration SHALL become active in the cycle after capture, and cfgReady SHALL return high then.
REQ-028 cfgValid while cfgReady=0 SHALL be ignored, and the pending value SHALL be unchanged.
REQ-029 If capture and activation fall in the same cycle, the previously pending value SHALL be activated and the new one SHALL remain pending.

Reset
REQ-030 While reset is high, the following SHALL hold immediately:
- state=IDLE;
- selector=2'b11, anodes=4'b1111, frameStart=0, cfgReady=1;
- active brightness=4'hF and active blankMask=4'b0000;
- pending register cleared;
- counters at 0.
REQ-031 Reset asserted mid-scan or mid-handshake SHALL discard the pending configuration.
REQ-032 After reset release, the block SHALL sit in IDLE until enable=1.

Structure
REQ-033 A shared package SHALL hold the digit select constants (SEL_A..SEL_D) and the state enumeration, for reuse by the nibble mux and the segment decoder.
REQ-034 The sub-module refresh_timer SHALL contain the slot and phase counters and produce slotWrap, phase and inDeadTime.

Verification (REFRESH_DIV=64, DEAD_CYCLES=2)
REQ-035 Reset, then enable=1, default configuration:
- selector sequence 11,10,01,00,11 at 64-cycle intervals;
- anodes 0111 from cycle 2 to cycle 63 of slot A;
- frameStart pulses every 256 cycles.
REQ-036 Brightness=4:
- in each slot, the anode is low only while phase is 0..3 (cycles 2–15);
- brightness=0 gives anodes=4'b1111 throughout.
REQ-037 Configuration in mid-frame (blankMask=4'b0100, brightness=15) presented during the digit-C slot:
- cfgReady is low until the next frameStart;
- the mask takes effect there, and digit B stays dark for every later frame.
REQ-038 Handshake collision: a second cfgValid while cfgReady=0 is dropped; a third cfgValid coincident with activation is captured and applied one frame later.
REQ-039 enable dropped at slot cycle 30 of digit C: next cycle anodes=4'b1111 and selector=2'b11; re-enable restarts at slot A cycle 0 with frameStart.
REQ-040 Reset asserted for 1 cycle during slot B with a configuration pending: outputs return to reset values asynchronously; the pending configuration is lost and cfgReady=1.
